sonic_vc_demultiplexer_0: RTL and testbench

Channelized Avalon-ST packet demultiplexer for the SoNIC virtual-channel path. It receives the single 128-bit stream produced by the VC multiplexer, with a 1-bit channel tag, and steers each whole packet to output port 0 or 1. The port is chosen on the start-of-packet beat. Each output has a one-beat registered pipeline stage, and the block counts protocol violations for host status.

---
 rtl/sonic_vc_demultiplexer_0_if.sv | 27 ++
 rtl/sonic_vc_demultiplexer_0.sv | 144 ++++++++++++++
 tb/tb_sonic_vc_demultiplexer_0.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sonic_vc_demultiplexer_0_if.sv
// Avalon-ST beat bundle with channel tag for the SoNIC VC path.
// master drives valid/data/framing/channel, slave drives ready.
interface sonic_vc_demultiplexer_0_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int EMPTY_WIDTH = 2
);
  logic                   valid;
  logic                   ready;
  logic                   channel;
  logic [DATA_WIDTH-1:0]  data;
  logic                   error;
  logic                   startofpacket;
  logic                   endofpacket;
  logic [EMPTY_WIDTH-1:0] empty;

  modport master (
    output valid, channel, data, error,
    output startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  valid, channel, data, error,
    input  startofpacket, endofpacket, empty,
    output ready
  );
endinterface

// File: rtl/sonic_vc_demultiplexer_0.sv
// Packet demux: steers whole packets to out0/out1 by the SOP channel tag.
// Ports: clk, reset_n, in_st (slave), out0_st/out1_st (master), drop/viol counters.
module sonic_vc_demultiplexer_0 #(
  parameter int DATA_WIDTH  = 128,
  parameter int EMPTY_WIDTH = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sonic_vc_demultiplexer_0_if.slave  in_st,
  sonic_vc_demultiplexer_0_if.master out0_st,
  sonic_vc_demultiplexer_0_if.master out1_st,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [CNT_WIDTH-1:0]  viol_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic                   error;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
  } beat_t;

  typedef enum logic {S_IDLE, S_PKT} state_e;

  state_e               state_q, state_d;
  logic                 lock_q, lock_d;
  logic [1:0]           vld_q, vld_d;
  beat_t [1:0]          pay_q, pay_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] viol_q, viol_d;

  logic [1:0] ordy;
  logic [1:0] load;
  logic       orphan;
  logic       mismatch;
  logic       tgt;
  logic       in_ready;
  logic       accept;
  logic       drop_inc;
  logic       viol_inc;
  beat_t      beat_in;

  assign ordy = {out1_st.ready, out0_st.ready};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (accept && !orphan) begin
      state_d = in_st.endofpacket ? S_IDLE : S_PKT;
      if (in_st.startofpacket) lock_d = in_st.channel;
    end
  end

  // A SOP seen mid-packet restarts on its own channel;
  // only continuation beats follow the latched port.
  always_comb begin
    orphan   = 1'b0;
    mismatch = 1'b0;
    tgt      = in_st.channel;
    unique case (state_q)
      S_IDLE: orphan = !in_st.startofpacket;
      S_PKT: begin
        if (!in_st.startofpacket) begin
          tgt      = lock_q;
          mismatch = in_st.channel != lock_q;
        end
      end
    endcase
    in_ready = reset_n
             && (orphan || ordy[tgt] || !vld_q[tgt]);
    accept   = in_st.valid && in_ready;
    load     = 2'b00;
    if (accept && !orphan) load[tgt] = 1'b1;
    drop_inc = accept && orphan;
    viol_inc = accept && (state_q == S_PKT)
             && (in_st.startofpacket || mismatch);
  end

  always_comb begin
    beat_in = '{
      data:  in_st.data,
      error: in_st.error | mismatch,
      sop:   in_st.startofpacket,
      eop:   in_st.endofpacket,
      empty: in_st.empty
    };
    for (int n = 0; n < 2; n++) begin
      vld_d[n] = load[n] | (vld_q[n] & ~ordy[n]);
      pay_d[n] = load[n] ? beat_in : pay_q[n];
    end
    drop_d = (drop_inc && drop_q != '1)
           ? drop_q + 1'b1 : drop_q;
    viol_d = (viol_inc && viol_q != '1)
           ? viol_q + 1'b1 : viol_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      pay_q  <= '0;
      drop_q <= '0;
      viol_q <= '0;
    end else begin
      vld_q  <= vld_d;
      pay_q  <= pay_d;
      drop_q <= drop_d;
      viol_q <= viol_d;
    end
  end

  assign in_st.ready = in_ready;

  assign out0_st.valid         = vld_q[0];
  assign out0_st.channel       = 1'b0;
  assign out0_st.data          = pay_q[0].data;
  assign out0_st.error         = pay_q[0].error;
  assign out0_st.startofpacket = pay_q[0].sop;
  assign out0_st.endofpacket   = pay_q[0].eop;
  assign out0_st.empty         = pay_q[0].empty;

  assign out1_st.valid         = vld_q[1];
  assign out1_st.channel       = 1'b1;
  assign out1_st.data          = pay_q[1].data;
  assign out1_st.error         = pay_q[1].error;
  assign out1_st.startofpacket = pay_q[1].sop;
  assign out1_st.endofpacket   = pay_q[1].eop;
  assign out1_st.empty         = pay_q[1].empty;

  assign drop_count = drop_q;
  assign viol_count = viol_q;

endmodule

// File: tb/tb_sonic_vc_demultiplexer_0.sv
// Bench for sonic_vc_demultiplexer_0: directed + random beats,
// packet-level reference model feeding per-port scoreboards.
module tb_sonic_vc_demultiplexer_0;
  localparam int DW = 128;
  localparam int EW = 2;
  localparam int CW = 16;
  localparam int CMAX = 65535;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sonic_vc_demultiplexer_0_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) in_if ();
  sonic_vc_demultiplexer_0_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) o0 ();
  sonic_vc_demultiplexer_0_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) o1 ();

  logic [CW-1:0] drop_count;
  logic [CW-1:0] viol_count;

  sonic_vc_demultiplexer_0 #(
    .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_st(in_if),
    .out0_st(o0),
    .out1_st(o1),
    .drop_count(drop_count),
    .viol_count(viol_count)
  );

  int chks = 0;
  int errs = 0;

  bit   rand_rdy = 0;
  logic r0 = 1'b1, r1 = 1'b1;
  logic rr0 = 1'b1, rr1 = 1'b1;
  assign o0.ready = rand_rdy ? rr0 : r0;
  assign o1.ready = rand_rdy ? rr1 : r1;

  always @(posedge clk) begin
    #1;
    rr0 = $urandom_range(0, 3) != 0;
    rr1 = $urandom_range(0, 3) != 0;
  end

  // reference model state
  beat_t q0[$];
  beat_t q1[$];
  bit    m_pkt = 0;
  bit    m_lock = 0;
  int    m_drop = 0;
  int    m_viol = 0;

  task automatic check(input string n, input logic [255:0] a,
                       input logic [255:0] x);
    chks++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Packet-level rules: returns destination port, or -1 for a dropped beat.
  function automatic int model(input beat_t b, input bit ch);
    int    dest;
    beat_t o;
    o = b;
    if (!m_pkt && !b.sop) begin
      m_drop = sat(m_drop);
      return -1;
    end
    dest = (!m_pkt || b.sop) ? int'(ch) : int'(m_lock);
    if (m_pkt) begin
      if (b.sop) m_viol = sat(m_viol);
      else if (ch != m_lock) begin
        o.err = 1'b1;
        m_viol = sat(m_viol);
      end
    end
    if (dest == 0) q0.push_back(o);
    else q1.push_back(o);
    if (b.sop) m_lock = ch;
    m_pkt = !b.eop;
    return dest;
  endfunction

  task automatic send(input logic ch, input logic sop, input logic eop,
                      input logic [DW-1:0] d, input logic e,
                      input logic [EW-1:0] emp, input bit now);
    int    w = 0;
    int    dest = -1;
    bit    ok = 0;
    beat_t b;
    b = '{data: d, err: e, sop: sop, eop: eop, empty: emp};
    in_if.valid = 1'b1;
    in_if.channel = ch;
    in_if.data = d;
    in_if.error = e;
    in_if.startofpacket = sop;
    in_if.endofpacket = eop;
    in_if.empty = emp;
    while (!ok && w < 1000) begin
      @(negedge clk);
      if (in_if.ready) begin
        ok = 1;
        dest = model(b, ch);
      end else w++;
    end
    if (!ok) begin
      chks++;
      errs++;
      $display("FAIL send_timeout: in_ready low for %0d cycles", w);
    end
    if (now) check("no_bubble_wait", w, 0);
    @(posedge clk);
    #1;
    if (dest == 0) begin
      check("lat_out0_valid", o0.valid, 1);
      check("lat_out0_data", o0.data, d);
    end else if (dest == 1) begin
      check("lat_out1_valid", o1.valid, 1);
      check("lat_out1_data", o1.data, d);
    end
  endtask

  task automatic settle(input int n);
    in_if.valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string n);
    check({n, "_drop"}, drop_count, m_drop);
    check({n, "_viol"}, viol_count, m_viol);
  endtask

  // scoreboard monitor
  beat_t a0, a1, hb0, hb1;
  bit    hv0 = 0, hv1 = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      a0 = '{o0.data, o0.error, o0.startofpacket, o0.endofpacket, o0.empty};
      a1 = '{o1.data, o1.error, o1.startofpacket, o1.endofpacket, o1.empty};
      if (hv0 && o0.valid) check("out0_hold", a0, hb0);
      if (hv1 && o1.valid) check("out1_hold", a1, hb1);
      if (o0.valid && o0.ready) begin
        if (q0.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL out0_unexpected: got %0h expected none", a0);
        end else check("out0_beat", a0, q0.pop_front());
      end
      if (o1.valid && o1.ready) begin
        if (q1.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL out1_unexpected: got %0h expected none", a1);
        end else check("out1_beat", a1, q1.pop_front());
      end
      hv0 = o0.valid && !o0.ready;
      hv1 = o1.valid && !o1.ready;
      hb0 = a0;
      hb1 = a1;
    end else begin
      hv0 = 0;
      hv1 = 0;
    end
  end

  initial begin
    logic [DW-1:0] d;
    bit            ch, sop, eop;

    in_if.valid = 1'b0;
    in_if.channel = 1'b0;
    in_if.data = '0;
    in_if.error = 1'b0;
    in_if.startofpacket = 1'b0;
    in_if.endofpacket = 1'b0;
    in_if.empty = '0;

    #12;
    check("rst_in_ready", in_if.ready, 0);
    check("rst_out0_valid", o0.valid, 0);
    check("rst_out1_valid", o1.valid, 0);
    check("rst_out0_data", o0.data, 0);
    check("rst_drop", drop_count, 0);
    check("rst_viol", viol_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 3-beat packet to port 1
    send(1, 1, 0, 128'h1, 0, 0, 1);
    check("p1_out0_idle", o0.valid, 0);
    send(1, 0, 0, 128'h2, 0, 0, 1);
    send(1, 0, 1, 128'h3, 0, 2'd3, 1);
    settle(2);
    check("p1_out0_idle_end", o0.valid, 0);
    check_counts("p1");

    // alternating single-beat packets, no bubbles
    for (int i = 0; i < 4; i++)
      send(i[0], 1, 1, 128'hA0 + 128'(i), 0, 2'(i), 1);
    settle(2);

    // stall port 0 mid-packet, toggle port 1 ready
    send(0, 1, 0, 128'hB1, 0, 0, 1);
    r0 = 1'b0;
    in_if.valid = 1'b1;
    in_if.channel = 1'b0;
    in_if.data = 128'hB2;
    in_if.startofpacket = 1'b0;
    in_if.endofpacket = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_if.ready, 0);
      check("stall_out0_data", o0.data, 128'hB1);
      r1 = ~r1;
    end
    @(posedge clk);
    #1;
    r0 = 1'b1;
    r1 = 1'b1;
    send(0, 0, 0, 128'hB2, 0, 0, 0);
    send(0, 0, 1, 128'hB3, 1, 1, 1);
    settle(2);

    // orphans in IDLE, even with port 0 held
    send(0, 1, 1, 128'hC0, 0, 0, 1);
    r0 = 1'b0;
    send(0, 0, 0, 128'hD1, 0, 0, 1);
    send(1, 0, 1, 128'hD2, 0, 0, 1);
    r0 = 1'b1;
    send(0, 1, 0, 128'hD3, 0, 0, 0);
    send(0, 0, 1, 128'hD4, 0, 0, 1);
    settle(2);
    check("orphan_drop2", drop_count, 2);
    check_counts("orphan");

    // channel mismatch then SOP before EOP
    send(0, 1, 0, 128'hE1, 0, 0, 1);
    send(1, 0, 0, 128'hE2, 0, 0, 1);
    check("mm_err_forced", o0.error, 1);
    send(1, 1, 0, 128'hE3, 0, 0, 1);
    send(1, 0, 1, 128'hE4, 0, 0, 1);
    settle(2);
    check("mm_viol2", viol_count, 2);
    check_counts("mm");

    // randomized traffic
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) settle($urandom_range(0, 2));
      sop = $urandom_range(0, 9) < (m_pkt ? 1 : 8);
      eop = $urandom_range(0, 2) == 0;
      if (m_pkt && !sop)
        ch = ($urandom_range(0, 7) == 0) ? !m_lock : m_lock;
      else
        ch = $urandom_range(0, 1);
      d = {$urandom, $urandom, $urandom, $urandom};
      send(ch, sop, eop, d, $urandom_range(0, 7) == 0,
           2'($urandom), 0);
    end
    rand_rdy = 0;
    settle(4);
    check_counts("rand");
    check("rand_q0_drained", q0.size(), 0);
    check("rand_q1_drained", q1.size(), 0);

    // asynchronous reset mid-packet
    send(1, 1, 1, 128'hF0, 0, 0, 1);
    r0 = 1'b0;
    send(0, 1, 0, 128'hF1, 0, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out0_valid", o0.valid, 0);
    check("arst_in_ready", in_if.ready, 0);
    check("arst_drop", drop_count, 0);
    in_if.valid = 1'b0;
    q0.delete();
    q1.delete();
    m_pkt = 0;
    m_lock = 0;
    m_drop = 0;
    m_viol = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    r0 = 1'b1;
    send(0, 0, 1, 128'hF2, 0, 0, 1);
    settle(2);
    check("arst_drop1", drop_count, 1);
    check("arst_out0_quiet", o0.valid, 0);
    check_counts("arst");

    // saturate the violation counter
    send(0, 1, 0, 128'h100, 0, 0, 1);
    for (int i = 0; i < 65540; i++)
      send(i[0], 1, 0, 128'(i), 0, 0, 0);
    send(1, 0, 1, 128'h200, 0, 0, 0);
    settle(3);
    check("sat_viol", viol_count, 16'hFFFF);
    check_counts("sat");
    check("end_q0_empty", q0.size(), 0);
    check("end_q1_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
